// File: rtl/controller_frame_sampler.sv
// controller_frame_sampler
//   Registers controller button bytes from the UART receiver, aligns them to
//   the 60 Hz game frame tick, buffers jump presses for a few frames and
//   zeroes every button when the ESP32 link goes silent.
//
// Parameters
//   TIMEOUT_CYCLES   clk cycles without a byte before the link is lost
//   JUMP_BUF_FRAMES  frames a jump press stays buffered (1..15)
//
// Ports
//   clk            system clock
//   rst            asynchronous, active-high reset
//   rx_data        button byte: [0]jump [1]dash [2]L [3]R [4]U [5]D [6]Y
//                  [7]ESP32 connected
//   rx_valid       one-cycle strobe, rx_data valid
//   frame_tick     one-cycle strobe at the start of each game frame
//   jump_consume   one-cycle strobe, game FSM used the buffered jump
//   held           button levels sampled at the last frame tick
//   pressed        buttons with a rising edge during the last frame
//   jump_buffered  jump press pending, not yet consumed or expired
//   connected      live[7] and link alive
//   link_timeout   no byte for TIMEOUT_CYCLES (or none since reset)

module controller_frame_sampler #(
    parameter int unsigned TIMEOUT_CYCLES  = 10_000_000,
    parameter int unsigned JUMP_BUF_FRAMES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       frame_tick,
    input  logic       jump_consume,
    output logic [6:0] held,
    output logic [6:0] pressed,
    output logic       jump_buffered,
    output logic       connected,
    output logic       link_timeout
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CW-1:0] WD_MAX  = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] WD_ONE  = CW'(1);
    localparam logic [3:0]    JRELOAD = 4'(JUMP_BUF_FRAMES);

    // ------------------------------------------------------------------
    // Reset conditioning: assertion is immediate, release is aligned to
    // the clock through a two-flop chain so no register sees a release
    // edge near its clock edge.
    // ------------------------------------------------------------------
    logic [1:0] rst_pipe;
    logic       rst_int;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_pipe <= 2'b11;
        end else begin
            rst_pipe <= {rst_pipe[0], 1'b0};
        end
    end

    assign rst_int = rst_pipe[1];

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CW-1:0] wd_cnt;
    logic [7:0]    live;
    logic [7:0]    live_q;
    logic [6:0]    press_acc;
    logic [3:0]    jcnt;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    logic [CW-1:0] wd_next;
    logic          lt_next;
    logic [7:0]    live_next;
    logic [6:0]    edges;
    logic [6:0]    frame_press;
    logic [3:0]    jcnt_next;

    // Watchdog: clears on every byte, otherwise counts up and saturates.
    // The link is lost exactly when the count arrives at the limit, so
    // link_timeout is simply "count is at the limit" one cycle ahead.
    always_comb begin
        wd_next = wd_cnt;
        if (rx_valid) begin
            wd_next = '0;
        end else if (wd_cnt != WD_MAX) begin
            wd_next = wd_cnt + WD_ONE;
        end
    end

    assign lt_next = ~rx_valid & (wd_next == WD_MAX);

    // A byte always wins over the timeout because rx_valid also clears
    // the timeout in the same cycle.
    always_comb begin
        live_next = live;
        if (rx_valid) begin
            live_next = rx_data;
        end else if (lt_next) begin
            live_next = 8'h00;
        end
    end

    // Only rising edges are collected, so the forced fall of live on a
    // timeout never shows up as a press.
    assign edges       = live[6:0] & ~live_q[6:0];
    assign frame_press = press_acc | edges;

    // Jump buffer priority: reload on a fresh press at the tick beats a
    // same-cycle consume; consume beats the per-frame decrement.
    always_comb begin
        jcnt_next = jcnt;
        if (frame_tick && frame_press[0]) begin
            jcnt_next = JRELOAD;
        end else if (jump_consume) begin
            jcnt_next = 4'd0;
        end else if (frame_tick && (jcnt != 4'd0)) begin
            jcnt_next = jcnt - 4'd1;
        end
    end

    // ------------------------------------------------------------------
    // Link tracking
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst_int) begin
        if (rst_int) begin
            wd_cnt       <= WD_MAX;
            link_timeout <= 1'b1;
            live         <= 8'h00;
            live_q       <= 8'h00;
            connected    <= 1'b0;
        end else begin
            wd_cnt       <= wd_next;
            link_timeout <= lt_next;
            live         <= live_next;
            live_q       <= live;
            connected    <= live_next[7] & ~lt_next;
        end
    end

    // ------------------------------------------------------------------
    // Frame alignment
    // ------------------------------------------------------------------
    // A byte arriving on a tick cycle only lands in live after the tick,
    // so the tick samples the old value and the new byte's edges go to
    // the following frame.
    always_ff @(posedge clk or posedge rst_int) begin
        if (rst_int) begin
            press_acc <= 7'h00;
            held      <= 7'h00;
            pressed   <= 7'h00;
        end else if (frame_tick) begin
            press_acc <= 7'h00;
            held      <= live[6:0];
            pressed   <= frame_press;
        end else begin
            press_acc <= frame_press;
        end
    end

    // ------------------------------------------------------------------
    // Jump buffer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst_int) begin
        if (rst_int) begin
            jcnt          <= 4'd0;
            jump_buffered <= 1'b0;
        end else begin
            jcnt          <= jcnt_next;
            jump_buffered <= (jcnt_next != 4'd0);
        end
    end

endmodule
